regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bits per register.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 5, register address width.
REQ-003 SHALL have parameter NUM_REGS, default 32, number of registers; legal range 2..2^ADDRESS_WIDTH.
REQ-004 SHALL have parameter NUM_RD_PORTS, default 2, independent read ports; legal range 1..4.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-006 wr_en  input  2  per-write-port enable; bit p belongs to write port p.
REQ-007 wr_dest  input  2*ADDRESS_WIDTH  write addresses; port p occupies slice [p*ADDRESS_WIDTH +: ADDRESS_WIDTH].
REQ-008 wr_data  input  2*DATA_WIDTH  write data, sliced the same way.
REQ-009 rsv_en  input  1  scoreboard reserve request (destination issued, result pending).
REQ-010 rsv_dest  input  ADDRESS_WIDTH  register to mark busy.
REQ-011 rd_addr  input  NUM_RD_PORTS*ADDRESS_WIDTH  read addresses, sliced per port.
REQ-012 rd_data  output  NUM_RD_PORTS*DATA_WIDTH  read data, sliced per port.
REQ-013 rd_busy  output  NUM_RD_PORTS  busy flag of each addressed register.
REQ-014 busy_vec  output  NUM_REGS  full scoreboard, bit r = register r busy.

Function
REQ-015 Register storage and the busy bits SHALL update on the rising edge of clk only; reads SHALL be combinational.
REQ-016 Register 0 SHALL read as 0 with busy 0; writes and reservations to address 0 SHALL be ignored.
REQ-017 A write with wr_en[p]=1 SHALL store wr_data slice p into wr_dest slice p at the clock edge.
REQ-018 Both write ports targeting the same register in one cycle: port 1 data SHALL win.
REQ-019 Addresses >= NUM_REGS SHALL be ignored for writes and reservations, and SHALL read data 0, busy 0.
REQ-020 A write to register r SHALL clear busy[r] at the same edge.
REQ-021 rsv_en=1 SHALL set busy[rsv_dest] at the edge.
REQ-022 Reservation and write to the same register in one cycle: busy SHALL end 1 (reserve wins), data SHALL still be written.
REQ-023 Reserving an already-busy register SHALL leave it busy; no error or counter.
REQ-024 rd_busy[k] SHALL equal busy_vec[rd_addr slice k] as registered, with no same-cycle bypass of busy.
REQ-025 Reads at a port SHALL NOT affect state; all read ports SHALL be mutually independent.

Reset
REQ-026 While rst=1 (asynchronous to clk), all registers SHALL be 0, busy_vec SHALL be 0, and writes and reservations SHALL be ignored.
REQ-027 Outputs during and immediately after reset: rd_data 0, rd_busy 0, busy_vec 0.
REQ-028 Reset released mid-cycle SHALL take effect on the first rising edge with rst=0; no partial write.

Configuration
REQ-029 Macro REGFILE_MP_BYPASS_EN defined: rd_data slice k SHALL return the same-cycle write data when a write port with enable set targets rd_addr slice k (port 1 over port 0; not for register 0 or out-of-range addresses).
REQ-030 Macro REGFILE_MP_BYPASS_EN undefined: rd_data SHALL return only stored contents; a write is visible the cycle after its edge.

Verification
REQ-031 Assert rst mid-cycle after writing 0xDEADBEEF to r5 -> r5 reads 0 immediately, before any clk edge; busy_vec=0.
REQ-032 Write r3=0x11 via port 0 and r3=0x22 via port 1 in the same cycle -> next cycle r3 reads 0x22.
REQ-033 Write r0=0xFFFFFFFF and reserve r0 -> r0 reads 0; busy_vec[0]=0.
REQ-034 Reserve r7, then a cycle later write r7=0x5 -> rd_busy=1 for one cycle, then 0 with data 0x5; write r7 and reserve r7 in the same cycle -> busy stays 1.
REQ-035 With REGFILE_MP_BYPASS_EN, port 0 writes r9=0xA5 while read port 1 addresses r9 -> rd_data 0xA5 in the same cycle; without the macro -> old value, then 0xA5 next cycle.
REQ-036 With NUM_RD_PORTS=4, NUM_REGS=20, read address 25 on all ports -> data 0, busy 0; a write to address 25 leaves every register unchanged.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: register file with 2 write ports, NUM_RD_PORTS combinational read ports and a busy scoreboard.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_REGS      = 32,
    parameter int NUM_RD_PORTS  = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [1:0]                            wr_en,
    input  logic [2*ADDRESS_WIDTH-1:0]            wr_dest,
    input  logic [2*DATA_WIDTH-1:0]               wr_data,
    input  logic                                  rsv_en,
    input  logic [ADDRESS_WIDTH-1:0]              rsv_dest,
    input  logic [NUM_RD_PORTS*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]    rd_data,
    output logic [NUM_RD_PORTS-1:0]               rd_busy,
    output logic [NUM_REGS-1:0]                   busy_vec
);
    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;

    // Register 0 has no storage; matching only indices 1..NUM_REGS-1 drops r0 and out-of-range addresses.
    logic [DW-1:0]       mem_q [1:NUM_REGS-1];
    logic [DW-1:0]       mem_d [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] busy_q, busy_d;

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int p = 0; p < 2; p++)
            for (int r = 1; r < NUM_REGS; r++)
                if (wr_en[p] && wr_dest[p*AW +: AW] == AW'(r)) begin
                    mem_d[r]  = wr_data[p*DW +: DW];
                    busy_d[r] = 1'b0;
                end
        for (int r = 1; r < NUM_REGS; r++)
            if (rsv_en && rsv_dest == AW'(r))
                busy_d[r] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q  <= '{default: '0};
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD_PORTS; k++)
            for (int r = 1; r < NUM_REGS; r++)
                if (rd_addr[k*AW +: AW] == AW'(r)) begin
                    rd_data[k*DW +: DW] = mem_q[r];
                    rd_busy[k]          = busy_q[r];
`ifdef REGFILE_MP_BYPASS_EN
                    for (int p = 0; p < 2; p++)
                        if (!rst && wr_en[p] && wr_dest[p*AW +: AW] == AW'(r))
                            rd_data[k*DW +: DW] = wr_data[p*DW +: DW];
`endif
                end
    end

    assign busy_vec = {busy_q, 1'b0};
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: table-driven checks of regfile_mp plus hand sequences for bypass, reset and a small 4-port/20-register instance.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_dest = '0;
    logic [63:0] wr_data = '0;
    logic        rsv_en = 1'b0;
    logic [4:0]  rsv_dest = '0;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [31:0] busy_vec;

    logic [1:0]   s_wr_en = '0;
    logic [9:0]   s_wr_dest = '0;
    logic [63:0]  s_wr_data = '0;
    logic         s_rsv_en = 1'b0;
    logic [4:0]   s_rsv_dest = '0;
    logic [19:0]  s_rd_addr = '0;
    logic [127:0] s_rd_data;
    logic [3:0]   s_rd_busy;
    logic [19:0]  s_busy_vec;

    int total = 0;
    int bad   = 0;

    regfile_mp dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_dest(wr_dest), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_dest(rsv_dest), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_busy(rd_busy), .busy_vec(busy_vec)
    );

    regfile_mp #(.NUM_REGS(20), .NUM_RD_PORTS(4)) dut_s (
        .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_dest(s_wr_dest), .wr_data(s_wr_data),
        .rsv_en(s_rsv_en), .rsv_dest(s_rsv_dest), .rd_addr(s_rd_addr),
        .rd_data(s_rd_data), .rd_busy(s_rd_busy), .busy_vec(s_busy_vec)
    );

    always #5 clk = ~clk;

`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        re;
        logic [4:0]  rsd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic [1:0]  eb;
        logic [31:0] ebv;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // Commit whatever is driven at the next edge, then drop all write/reserve strobes.
    task automatic cyc();
        @(posedge clk);
        #1;
        wr_en = '0; rsv_en = 1'b0; s_wr_en = '0; s_rsv_en = 1'b0;
        #1;
    endtask

    initial begin
        vt[0]  = '{2'b11, 5'd1,  32'h1111,     5'd2,  32'h2222, 1'b0, 5'd0,  5'd1,  5'd2,  32'h1111, 32'h2222, 2'b00, 32'h0};
        vt[1]  = '{2'b11, 5'd3,  32'h11,       5'd3,  32'h22,   1'b0, 5'd0,  5'd3,  5'd0,  32'h22,   32'h0,    2'b00, 32'h0};
        vt[2]  = '{2'b01, 5'd0,  32'hFFFFFFFF, 5'd0,  32'h0,    1'b1, 5'd0,  5'd0,  5'd1,  32'h0,    32'h1111, 2'b00, 32'h0};
        vt[3]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    1'b1, 5'd7,  5'd7,  5'd3,  32'h0,    32'h22,   2'b01, 32'h80};
        vt[4]  = '{2'b01, 5'd7,  32'h5,        5'd0,  32'h0,    1'b0, 5'd0,  5'd7,  5'd3,  32'h5,    32'h22,   2'b00, 32'h0};
        vt[5]  = '{2'b10, 5'd0,  32'h0,        5'd7,  32'h6,    1'b1, 5'd7,  5'd7,  5'd7,  32'h6,    32'h6,    2'b11, 32'h80};
        vt[6]  = '{2'b01, 5'd8,  32'h88,       5'd0,  32'h0,    1'b1, 5'd7,  5'd7,  5'd8,  32'h6,    32'h88,   2'b01, 32'h80};
        vt[7]  = '{2'b11, 5'd30, 32'h30,       5'd31, 32'hABCD, 1'b1, 5'd31, 5'd31, 5'd30, 32'hABCD, 32'h30,   2'b01, 32'h80000080};
        vt[8]  = '{2'b10, 5'd0,  32'h0,        5'd7,  32'h77,   1'b0, 5'd0,  5'd7,  5'd31, 32'h77,   32'hABCD, 2'b10, 32'h80000000};
        vt[9]  = '{2'b00, 5'd1,  32'hBAD,      5'd2,  32'hBAD,  1'b0, 5'd0,  5'd1,  5'd2,  32'h1111, 32'h2222, 2'b00, 32'h80000000};
        vt[10] = '{2'b11, 5'd2,  32'h3333,     5'd1,  32'h4444, 1'b0, 5'd0,  5'd1,  5'd2,  32'h4444, 32'h3333, 2'b00, 32'h80000000};

        #1;
        chk("rst_rd_data", rd_data, 64'h0);
        chk("rst_rd_busy", {62'h0, rd_busy}, 64'h0);
        chk("rst_busy_vec", {32'h0, busy_vec}, 64'h0);
        chk("rst_s_busy_vec", {44'h0, s_busy_vec}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;

        for (int i = 0; i < 11; i++) begin
            wr_en = vt[i].we;
            wr_dest = {vt[i].wa1, vt[i].wa0};
            wr_data = {vt[i].wd1, vt[i].wd0};
            rsv_en = vt[i].re;
            rsv_dest = vt[i].rsd;
            cyc();
            rd_addr = {vt[i].ra1, vt[i].ra0};
            #1;
            chk($sformatf("v%0d_d0", i), {32'h0, rd_data[31:0]}, {32'h0, vt[i].ed0});
            chk($sformatf("v%0d_d1", i), {32'h0, rd_data[63:32]}, {32'h0, vt[i].ed1});
            chk($sformatf("v%0d_busy", i), {62'h0, rd_busy}, {62'h0, vt[i].eb});
            chk($sformatf("v%0d_bvec", i), {32'h0, busy_vec}, {32'h0, vt[i].ebv});
            #1;
        end

        // Reservation must not show on rd_busy until after the edge.
        rsv_en = 1'b1; rsv_dest = 5'd12; rd_addr = {5'd0, 5'd12};
        #1;
        chk("rsv_same_cycle", {62'h0, rd_busy}, 64'h0);
        cyc();
        chk("rsv_next_cycle", {62'h0, rd_busy}, 64'h1);

        wr_en = 2'b01; wr_dest = {5'd0, 5'd9}; wr_data = {32'h0, 32'h11};
        cyc();
        rd_addr = {5'd9, 5'd0};
        #1;
        chk("r9_init", {32'h0, rd_data[63:32]}, 64'h11);
        wr_en = 2'b01; wr_data = {32'h0, 32'hA5};
        #1;
        chk("byp_p0_same", {32'h0, rd_data[63:32]}, BYP ? 64'hA5 : 64'h11);
        cyc();
        chk("byp_p0_next", {32'h0, rd_data[63:32]}, 64'hA5);
        wr_en = 2'b11; wr_dest = {5'd9, 5'd9}; wr_data = {32'hB1, 32'hB0}; rd_addr = {5'd0, 5'd9};
        #1;
        chk("byp_both_same", {32'h0, rd_data[31:0]}, BYP ? 64'hB1 : 64'hA5);
        cyc();
        chk("byp_both_next", {32'h0, rd_data[31:0]}, 64'hB1);
        wr_en = 2'b01; wr_dest = '0; wr_data = {32'h0, 32'hFF}; rd_addr = '0;
        #1;
        chk("byp_r0", rd_data, 64'h0);
        cyc();

        s_wr_en = 2'b11; s_wr_dest = {5'd1, 5'd19}; s_wr_data = {32'h1, 32'h19};
        s_rsv_en = 1'b1; s_rsv_dest = 5'd19;
        cyc();
        s_rd_addr = {4{5'd25}};
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("s_oor_d%0d", k), {32'h0, s_rd_data[k*32 +: 32]}, 64'h0);
            chk($sformatf("s_oor_b%0d", k), {63'h0, s_rd_busy[k]}, 64'h0);
        end
        s_wr_en = 2'b11; s_wr_dest = {5'd20, 5'd25}; s_wr_data = {32'hEEEE, 32'hFFFFFFFF};
        s_rsv_en = 1'b1; s_rsv_dest = 5'd25;
        cyc();
        s_rd_addr = {5'd20, 5'd19, 5'd1, 5'd0};
        #1;
        chk("s_bvec", {44'h0, s_busy_vec}, 64'h80000);
        chk("s_data", s_rd_data[127:64], {32'h0, 32'h19});
        chk("s_data_lo", s_rd_data[63:0], {32'h1, 32'h0});
        chk("s_busy", {60'h0, s_rd_busy}, 64'h4);
        for (int r = 1; r < 20; r++) begin
            s_rd_addr[19:15] = 5'(r);
            #1;
            chk($sformatf("s_sweep_r%0d", r), {32'h0, s_rd_data[127:96]},
                r == 1 ? 64'h1 : (r == 19 ? 64'h19 : 64'h0));
        end

        @(posedge clk);
        #2;
        wr_en = 2'b01; wr_dest = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
        cyc();
        rd_addr = {5'd0, 5'd5};
        #1;
        chk("pre_rst_r5", {32'h0, rd_data[31:0]}, 64'hDEADBEEF);
        chk("pre_rst_bvec", {32'h0, busy_vec}, 64'h80001000);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_r5", rd_data, 64'h0);
        chk("async_rst_bvec", {32'h0, busy_vec}, 64'h0);
        chk("async_rst_busy", {62'h0, rd_busy}, 64'h0);
        wr_en = 2'b01; wr_data = {32'h0, 32'h55}; rsv_en = 1'b1; rsv_dest = 5'd5;
        @(posedge clk);
        #1;
        chk("rst_blocks_wr", rd_data, 64'h0);
        chk("rst_blocks_rsv", {32'h0, busy_vec}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_no_edge", {32'h0, busy_vec}, 64'h0);
        cyc();
        chk("post_rst_wr", {32'h0, rd_data[31:0]}, 64'h55);
        chk("post_rst_rsv_wins", {62'h0, rd_busy}, 64'h1);
        chk("post_rst_bvec", {32'h0, busy_vec}, 64'h20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
